// File: rtl/pipe_pattern_checker_if.sv
// FIFO-side pipe bundle between an okPipeIn-style FIFO and the pattern checker.
// The FIFO (master) presents empty/valid/data; the checker (slave) returns the read strobe.
interface pipe_pattern_checker_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();

  logic                  pipe_in_empty;
  logic                  pipe_in_valid;
  logic [DATA_WIDTH-1:0] pipe_in_data;
  logic                  pipe_in_read;

  modport master (
    output pipe_in_empty,
    output pipe_in_valid,
    output pipe_in_data,
    input  pipe_in_read
  );

  modport slave (
    input  pipe_in_empty,
    input  pipe_in_valid,
    input  pipe_in_data,
    output pipe_in_read
  );

endinterface

// File: rtl/pipe_pattern_checker.sv
// Throttled pipe drain that checks each valid word, lane by lane, against a
// selectable pattern generator and keeps error/word counters plus first-error capture.
module pipe_pattern_checker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ERR_WIDTH  = 32,
  parameter int unsigned IDX_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           restart,
  input  logic [1:0]                     mode,
  input  logic [31:0]                    seed,
  input  logic                           throttle_set,
  input  logic [31:0]                    throttle_val,
  pipe_pattern_checker_if.slave          pipe,
  output logic [ERR_WIDTH-1:0]           error_count,
  output logic [IDX_WIDTH-1:0]           word_count,
  output logic [DATA_WIDTH/32-1:0]       lane_err_mask,
  output logic                           first_err_valid,
  output logic [IDX_WIDTH-1:0]           first_err_index
);

  localparam int unsigned NumLanes = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    ModeCounter = 2'd0,
    ModeLfsr    = 2'd1,
    ModeWalk    = 2'd2,
    ModeFixed   = 2'd3
  } mode_e;

  // Each lane keeps the value it expects for the *next* word, so the step
  // function is the only mode-dependent arithmetic on the datapath.
  function automatic logic [31:0] gen_init(mode_e m, logic [31:0] s, int unsigned lane);
    logic [31:0] v;
    unique case (m)
      ModeCounter: v = s + 32'(lane);
      ModeLfsr: begin
        v = s + 32'(lane);
        if (v == 32'h0) v = 32'h1;
      end
      ModeWalk:    v = 32'h1 << lane[4:0];
      default:     v = s;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] gen_step(mode_e m, logic [31:0] g);
    logic [31:0] v;
    unique case (m)
      ModeCounter: v = g + 32'(NumLanes);
      ModeLfsr:    v = {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
      ModeWalk:    v = {g[30:0], g[31]};
      default:     v = g;
    endcase
    return v;
  endfunction

  logic [31:0]                 thr_q, thr_d;
  mode_e                       mode_q, mode_d;
  logic [NumLanes-1:0][31:0]   gen_q, gen_d;
  logic [ERR_WIDTH-1:0]        err_q, err_d;
  logic [IDX_WIDTH-1:0]        word_q, word_d;
  logic [NumLanes-1:0]         mask_q, mask_d;
  logic                        fv_q, fv_d;
  logic [IDX_WIDTH-1:0]        fi_q, fi_d;

  logic [NumLanes-1:0]         mismatch;
  logic                        word_fire;

  assign word_fire = pipe.pipe_in_valid & ~restart;

  always_comb begin
    mismatch = '0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      mismatch[l] = (pipe.pipe_in_data[32*l +: 32] != gen_q[l]);
    end
  end

  // Gate with reset_n so no read can escape while the block is held in reset.
  assign pipe.pipe_in_read = reset_n & thr_q[31] & enable & ~pipe.pipe_in_empty & ~restart;

  always_comb begin
    thr_d  = throttle_set ? throttle_val : {thr_q[30:0], thr_q[31]};
    mode_d = mode_q;
    gen_d  = gen_q;
    err_d  = err_q;
    word_d = word_q;
    mask_d = mask_q;
    fv_d   = fv_q;
    fi_d   = fi_q;

    if (restart) begin
      mode_d = mode_e'(mode);
      for (int unsigned l = 0; l < NumLanes; l++) begin
        gen_d[l] = gen_init(mode_e'(mode), seed, l);
      end
      err_d  = '0;
      word_d = '0;
      mask_d = '0;
      fv_d   = 1'b0;
      fi_d   = '0;
    end else if (word_fire) begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        gen_d[l] = gen_step(mode_q, gen_q[l]);
      end
      word_d = word_q + IDX_WIDTH'(1);
      if (|mismatch) begin
        if (err_q != {ERR_WIDTH{1'b1}}) err_d = err_q + ERR_WIDTH'(1);
        mask_d = mask_q | mismatch;
        if (!fv_q) begin
          fv_d = 1'b1;
          fi_d = word_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q  <= 32'hFFFF_FFFF;
      mode_q <= ModeCounter;
      for (int unsigned l = 0; l < NumLanes; l++) begin
        gen_q[l] <= 32'(l);
      end
      err_q  <= '0;
      word_q <= '0;
      mask_q <= '0;
      fv_q   <= 1'b0;
      fi_q   <= '0;
    end else begin
      thr_q  <= thr_d;
      mode_q <= mode_d;
      gen_q  <= gen_d;
      err_q  <= err_d;
      word_q <= word_d;
      mask_q <= mask_d;
      fv_q   <= fv_d;
      fi_q   <= fi_d;
    end
  end

  assign error_count     = err_q;
  assign word_count      = word_q;
  assign lane_err_mask   = mask_q;
  assign first_err_valid = fv_q;
  assign first_err_index = fi_q;

endmodule

// File: tb/tb_pipe_pattern_checker.sv
// Scoreboard bench: the driver pushes expected status per valid word from a
// pattern-rule model; a monitor pops and compares one cycle after each accepted word.
module tb_pipe_pattern_checker;

  localparam int unsigned DW = 64;
  localparam int unsigned EW = 4;
  localparam int unsigned IW = 32;
  localparam int unsigned NL = DW / 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          enable;
  logic          restart;
  logic [1:0]    mode;
  logic [31:0]   seed;
  logic          throttle_set;
  logic [31:0]   throttle_val;
  logic [EW-1:0] error_count;
  logic [IW-1:0] word_count;
  logic [NL-1:0] lane_err_mask;
  logic          first_err_valid;
  logic [IW-1:0] first_err_index;

  pipe_pattern_checker_if #(.DATA_WIDTH(DW)) pipe_if ();

  pipe_pattern_checker #(
    .DATA_WIDTH(DW),
    .ERR_WIDTH (EW),
    .IDX_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .restart        (restart),
    .mode           (mode),
    .seed           (seed),
    .throttle_set   (throttle_set),
    .throttle_val   (throttle_val),
    .pipe           (pipe_if),
    .error_count    (error_count),
    .word_count     (word_count),
    .lane_err_mask  (lane_err_mask),
    .first_err_valid(first_err_valid),
    .first_err_index(first_err_index)
  );

  typedef struct {
    logic [EW-1:0] err;
    logic [IW-1:0] words;
    logic [NL-1:0] mask;
    logic          fv;
    logic [IW-1:0] fi;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: expected lane values derived from the pattern rules and word index k.
  logic [1:0]    m_mode;
  logic [31:0]   m_seed;
  int unsigned   m_k;
  logic [31:0]   m_lfsr [NL];
  logic [EW-1:0] m_err;
  logic [IW-1:0] m_words;
  logic [NL-1:0] m_mask;
  logic          m_fv;
  logic [IW-1:0] m_fi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_restart(input logic [1:0] md, input logic [31:0] sd);
    m_mode = md;
    m_seed = sd;
    m_k    = 0;
    for (int l = 0; l < NL; l++) begin
      m_lfsr[l] = sd + 32'(l);
      if (m_lfsr[l] == 32'h0) m_lfsr[l] = 32'h1;
    end
    m_err   = '0;
    m_words = '0;
    m_mask  = '0;
    m_fv    = 1'b0;
    m_fi    = '0;
  endfunction

  function automatic logic [31:0] exp_lane(input int unsigned l);
    case (m_mode)
      2'd0:    return m_seed + 32'(NL * m_k + l);
      2'd1:    return m_lfsr[l];
      2'd2:    return 32'h1 << ((m_k + l) % 32);
      default: return m_seed;
    endcase
  endfunction

  function automatic logic [DW-1:0] good_word();
    logic [DW-1:0] d;
    for (int l = 0; l < NL; l++) d[32*l +: 32] = exp_lane(l);
    return d;
  endfunction

  function automatic void model_word(input logic [DW-1:0] d);
    logic [NL-1:0] mm;
    exp_t          e;
    for (int l = 0; l < NL; l++) mm[l] = (d[32*l +: 32] !== exp_lane(l));
    if (mm != '0) begin
      if (m_err != '1) m_err = m_err + 1'b1;
      m_mask = m_mask | mm;
      if (!m_fv) begin
        m_fv = 1'b1;
        m_fi = m_words;
      end
    end
    m_words = m_words + 1'b1;
    for (int l = 0; l < NL; l++) begin
      m_lfsr[l] = {m_lfsr[l][30:0], m_lfsr[l][31] ^ m_lfsr[l][21] ^ m_lfsr[l][1] ^ m_lfsr[l][0]};
    end
    m_k++;
    e.err = m_err; e.words = m_words; e.mask = m_mask; e.fv = m_fv; e.fi = m_fi;
    sb_q.push_back(e);
  endfunction

  // Monitor: a word accepted at a rising edge shows up on the outputs by the next falling edge.
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = reset_n && pipe_if.pipe_in_valid && !restart;
      @(negedge clk);
      if (fire) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got output with no expected entry at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("error_count",     32'(error_count),     32'(e.err));
          chk("word_count",      32'(word_count),      32'(e.words));
          chk("lane_err_mask",   32'(lane_err_mask),   32'(e.mask));
          chk("first_err_valid", 32'(first_err_valid), 32'(e.fv));
          chk("first_err_index", 32'(first_err_index), 32'(e.fi));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_error_count"},     32'(error_count),     32'h0);
    chk({tag, "_word_count"},      32'(word_count),      32'h0);
    chk({tag, "_lane_err_mask"},   32'(lane_err_mask),   32'h0);
    chk({tag, "_first_err_valid"}, 32'(first_err_valid), 32'h0);
    chk({tag, "_first_err_index"}, 32'(first_err_index), 32'h0);
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    restart               = 1'b0;
    pipe_if.pipe_in_valid = 1'b1;
    pipe_if.pipe_in_data  = d;
    model_word(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      restart               = 1'b0;
      pipe_if.pipe_in_valid = 1'b0;
    end
  endtask

  task automatic do_restart(input logic [1:0] md, input logic [31:0] sd, input logic with_word);
    @(negedge clk);
    restart               = 1'b1;
    mode                  = md;
    seed                  = sd;
    enable                = 1'b1;
    pipe_if.pipe_in_empty = 1'b0;
    pipe_if.pipe_in_valid = with_word;
    pipe_if.pipe_in_data  = {$urandom(), $urandom()};
    model_restart(md, sd);
    #1 chk("read_during_restart", 32'(pipe_if.pipe_in_read), 32'h0);
    @(negedge clk);
    restart               = 1'b0;
    pipe_if.pipe_in_valid = 1'b0;
    chk_zero("after_restart");
  endtask

  initial begin
    logic [31:0]   mthr;
    logic [DW-1:0] d;
    int unsigned   lane;

    reset_n               = 1'b0;
    enable                = 1'b1;
    restart               = 1'b0;
    mode                  = 2'd0;
    seed                  = 32'h0;
    throttle_set          = 1'b0;
    throttle_val          = 32'h0;
    pipe_if.pipe_in_empty = 1'b0;
    pipe_if.pipe_in_valid = 1'b0;
    pipe_if.pipe_in_data  = '0;

    // Reset state: outputs zero and no read even with enable and a non-empty FIFO.
    repeat (2) @(negedge clk);
    chk_zero("reset");
    #1 chk("read_in_reset", 32'(pipe_if.pipe_in_read), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_restart(2'd0, 32'h0);
    #1 chk("read_after_reset", 32'(pipe_if.pipe_in_read), 32'h1);
    @(negedge clk);
    #1 chk("read_after_reset_2", 32'(pipe_if.pipe_in_read), 32'h1);
    pipe_if.pipe_in_empty = 1'b1;
    #1 chk("read_when_empty", 32'(pipe_if.pipe_in_read), 32'h0);
    pipe_if.pipe_in_empty = 1'b0;

    // Generator after reset behaves as counter mode with seed 0.
    send({32'd1, 32'd0});
    send({32'd3, 32'd2});
    send({32'd5, 32'd4});
    idle(2);

    // Counter stream with word 1 lane 1 corrupted; valid word in the restart cycle is dropped.
    do_restart(2'd0, 32'h0, 1'b1);
    send({32'd1, 32'd0});
    send({32'd6, 32'd2});
    send({32'd5, 32'd4});
    idle(2);

    // LFSR, seed 0 and seed all-ones, correct streams then a single corruption.
    do_restart(2'd1, 32'h0, 1'b0);
    repeat (5) send(good_word());
    do_restart(2'd1, 32'hFFFF_FFFF, 1'b0);
    repeat (4) send(good_word());
    d = good_word();
    d[7] = ~d[7];
    send(d);
    idle(2);

    // Fixed pattern against all-zero words: error counter saturates.
    do_restart(2'd3, 32'h5A5A_5A5A, 1'b0);
    repeat (20) send('0);
    idle(2);

    // Throttle pattern: alternating reads after the set pulse, forced off by empty.
    @(negedge clk);
    throttle_set = 1'b1;
    throttle_val = 32'hAAAA_AAAA;
    enable       = 1'b1;
    @(negedge clk);
    throttle_set = 1'b0;
    mthr         = 32'hAAAA_AAAA;
    #1 chk("throttle_read_0", 32'(pipe_if.pipe_in_read), 32'(mthr[31]));
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      mthr = {mthr[30:0], mthr[31]};
      #1 chk($sformatf("throttle_read_%0d", i), 32'(pipe_if.pipe_in_read), 32'(mthr[31]));
    end
    pipe_if.pipe_in_empty = 1'b1;
    #1 chk("throttle_read_empty", 32'(pipe_if.pipe_in_read), 32'h0);
    @(negedge clk);
    #1 chk("throttle_read_empty_2", 32'(pipe_if.pipe_in_read), 32'h0);
    pipe_if.pipe_in_empty = 1'b0;
    enable                = 1'b0;
    @(negedge clk);
    #1 chk("read_disabled", 32'(pipe_if.pipe_in_read), 32'h0);

    // Randomized rounds: random mode/seed, gaps, lane corruptions, enable toggling.
    for (int r = 0; r < 12; r++) begin
      do_restart(2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        enable = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 7) begin
          d = good_word();
          if ($urandom_range(0, 9) < 2) begin
            lane = $urandom_range(0, NL - 1);
            d[32*lane +: 32] = d[32*lane +: 32] ^ (32'h1 << $urandom_range(0, 31));
          end
          send(d);
        end else begin
          idle(1);
        end
      end
      idle(1);
    end

    // Mid-stream reset returns everything to reset values, including the throttle.
    @(negedge clk);
    throttle_set = 1'b1;
    throttle_val = 32'h0F0F_0F0F;
    @(negedge clk);
    throttle_set = 1'b0;
    do_restart(2'd2, 32'h1234_5678, 1'b0);
    repeat (3) send(good_word());
    idle(1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    chk("read_async_reset", 32'(pipe_if.pipe_in_read), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_restart(2'd0, 32'h0);
    enable                = 1'b1;
    pipe_if.pipe_in_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("read_post_reset_%0d", i), 32'(pipe_if.pipe_in_read), 32'h1);
      @(negedge clk);
    end
    send({32'd1, 32'd0});
    send({32'd3, 32'h7});
    idle(3);

    chk("scoreboard_leftover", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
